// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
// Holds the FSM encoding, counter sizing and the 1-bit full-adder cell.
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A single-step operation still needs a 1-bit counter.
    function automatic int cnt_width(input int steps);
        return (clog2(steps) < 1) ? 1 : clog2(steps);
    endfunction

    // Returns {carry_out, sum} of one full-adder cell.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/seq_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Also exposes the carry into its top bit for signed-overflow detection.
module digit_adder
    import seq_addsub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;
    logic [1:0]     fa;

    always_comb begin
        c    = '0;
        s    = '0;
        fa   = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            fa       = full_add(x[i], y[i], c[i]);
            s[i]     = fa[0];
            c[i+1]   = fa[1];
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a registered carry.
// Results appear only on the done pulse and are held until the next one.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("seq_addsub: DIGIT must be >= 1 and divide WIDTH");
    end

    // Handshake: start is accepted at an edge only in IDLE or DONE; operands
    // are captured at that edge. done pulses for one cycle when sum/cout/ovf
    // update; start while busy is dropped, start during done chains directly.
    state_e            state;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  acc;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [DIGIT-1:0]  d_s;
    logic              d_cout;
    logic              d_cmsb;
    logic [WIDTH-1:0]  acc_next;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (op_a[DIGIT-1:0]),
        .y     (op_b[DIGIT-1:0]),
        .cin   (carry),
        .s     (d_s),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // New digit enters at the top; after STEPS shifts the word is aligned.
    assign acc_next  = (acc >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    acc   <= acc_next;
                    carry <= d_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(STEPS - 1)) begin
                        sum   <= acc_next;
                        cout  <= d_cout;
                        ovf   <= d_cmsb ^ d_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: one DIGIT=1 and one DIGIT=4 instance, directed and
// random operations checked against an arithmetic reference model.
module tb_seq_addsub;
    import seq_addsub_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic       sub_i  = 1'b0;
    logic       cin_i  = 1'b0;
    logic [7:0] a_i    = 8'h00;
    logic [7:0] b_i    = 8'h00;

    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;
    logic [1:0] st1;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;
    logic [1:0] st4;

    seq_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub_i), .a(a_i), .b(b_i),
        .cin(cin_i), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .ovf(ovf1), .state_dbg(st1)
    );

    seq_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub_i), .a(a_i), .b(b_i),
        .cin(cin_i), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .ovf(ovf4), .state_dbg(st4)
    );

    // ---------------- scoreboard ----------------
    bit         sel = 1'b0;   // 0 = dut1, 1 = dut4
    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];     // {ovf, cout, sum}
    logic [9:0] last1 = '0;
    logic [9:0] last4 = '0;

    function automatic logic get_busy();
        return sel ? busy4 : busy1;
    endfunction
    function automatic logic get_done();
        return sel ? done4 : done1;
    endfunction
    function automatic logic [9:0] get_res();
        return sel ? {ovf4, cout4, sum4} : {ovf1, cout1, sum1};
    endfunction
    function automatic logic [1:0] get_state();
        return sel ? st4 : st1;
    endfunction

    // Plain integer arithmetic: unsigned result for sum/cout, signed range for ovf.
    function automatic logic [9:0] model(input logic s, input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
        int ua, ub, sa, sb, r, sr;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!s) begin
            r  = ua + ub + int'(c);
            sr = sa + sb + int'(c);
            co = (r > 255);
        end else begin
            r  = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end
        ov = (sr > 127) || (sr < -128);
        return {ov, co, r[7:0]};
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_start(input logic v);
        if (sel) start4 = v;
        else     start1 = v;
    endtask

    // Called at a negedge. poke: raise start mid-run; chain: leave in done cycle.
    task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit poke, input bit chain);
        int         steps;
        logic [9:0] held;
        logic [9:0] exp;
        steps = sel ? 2 : 8;
        held  = sel ? last4 : last1;
        exp_q.push_back(model(s, a, b, c));
        sub_i = s;
        a_i   = a;
        b_i   = b;
        cin_i = c;
        set_start(1'b1);
        @(posedge clk);
        for (int k = 1; k <= steps; k++) begin
            @(negedge clk);
            check_bit("busy", get_busy(), 1'b1);
            check_bit("done_early", get_done(), 1'b0);
            check_res("held", get_res(), held);
            if (k == 1) begin
                set_start(1'b0);
                sub_i = 1'($urandom);
                a_i   = 8'($urandom);
                b_i   = 8'($urandom);
                cin_i = 1'($urandom);
            end
            if (poke && k == 3) begin
                set_start(1'b1);
                a_i = 8'($urandom);
                b_i = 8'($urandom);
            end
            if (poke && k == 4) set_start(1'b0);
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        check_bit("done", get_done(), 1'b1);
        check_bit("busy_end", get_busy(), 1'b0);
        check_res("result", get_res(), exp);
        if (sel) last4 = exp;
        else     last1 = exp;
        if (!chain) begin
            @(negedge clk);
            check_bit("done_pulse", get_done(), 1'b0);
            check_bit("idle_busy", get_busy(), 1'b0);
            check_res("idle_state", 10'(get_state()), 10'(IDLE));
            check_res("hold_idle", get_res(), exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = bit'(d);
            check_bit("rst_busy", get_busy(), 1'b0);
            check_bit("rst_done", get_done(), 1'b0);
            check_res("rst_res", get_res(), 10'h000);
            check_res("rst_state", 10'(get_state()), 10'(IDLE));
        end
        sel   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        do_op(1'b1, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
        do_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        do_op(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 8'h7F, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Abort an operation with reset three cycles in.
        sub_i  = 1'b0;
        a_i    = 8'h33;
        b_i    = 8'h44;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_bit("abort_busy", get_busy(), 1'b0);
        check_bit("abort_done", get_done(), 1'b0);
        check_res("abort_res", get_res(), 10'h000);
        check_res("abort_state", 10'(get_state()), 10'(IDLE));
        last1 = '0;
        last4 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_bit("no_done_after_abort", get_done(), 1'b0);
        end
        check_res("abort_res_held", get_res(), 10'h000);
        do_op(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

        repeat (12) do_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                          1'b0, bit'($urandom_range(1, 0)));

        // Four bits per cycle, including a back-to-back chain.
        @(negedge clk);
        sel = 1'b1;
        do_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        do_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        repeat (12) do_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                          1'b0, bit'($urandom_range(1, 0)));
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It processes DIGIT bits per clock through a registered carry, so WIDTH-bit operands finish in WIDTH/DIGIT cycles. It generalises the team's 1-bit full-adder cell into a sequential datapath with a start/done handshake, a subtract mode, and signed-overflow detection. It is used where ALU area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits
DIGIT, 1, bits processed per cycle; must divide WIDTH, else elaboration error
STEPS (localparam), WIDTH/DIGIT, cycles per operation

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
sub  in  1  0 = a+b+cin, 1 = a-b (cin ignored)
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B, captured on accepted start
cin  in  1  carry-in for add, captured on accepted start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; results valid from this cycle
sum  out  WIDTH  result; held until next done
cout  out  1  carry out; in sub mode, 1 = no borrow (a >= b unsigned)
ovf  out  1  two's-complement overflow (carry into MSB xor carry out of MSB)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, sum, cout, ovf = 0; internal shift registers, carry and counter = 0. Takes effect immediately, including mid-operation. The aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at an edge:
  - load opA=a, opB = sub ? ~b : b, carry = sub ? 1 : cin, cnt=0
  - go to RUN
- DONE with start=0: go to IDLE. done is high only while in DONE.
- RUN, each edge:
  - digit_adder adds opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry
  - digit result shifted into the top of the result shift register (shift right by DIGIT); opA and opB shift right by DIGIT
  - carry updated; cnt incremented
  - on the edge where cnt == STEPS-1: load sum from the final shift value, cout = final carry, ovf = carry-into-MSB xor final carry; go to DONE
- Latency: start sampled at edge E; done=1 in the cycle after edge E+STEPS. Example: WIDTH=8, DIGIT=1 gives done 8 cycles after the start edge.
- busy=1 exactly STEPS cycles per operation.
- start while busy: ignored; no queuing, operands not recaptured.
- start in the done cycle: accepted; back-to-back operations with no IDLE gap. busy rises the next cycle; sum, cout, ovf hold the old values until the new done.
- sum, cout and ovf never change outside a done cycle or reset. Intermediate values are not visible on the outputs.
- a, b, cin and sub may change freely after the accepting edge.
- DIGIT == WIDTH is legal: STEPS=1, done two edges after start.

Decomposition:
- Package seq_addsub_pkg:
  - state enum {IDLE, RUN, DONE}
  - function clog2 for counter width; counter width = max(1, clog2(STEPS))
- Sub-module digit_adder #(DIGIT):
  - combinational ripple chain of 1-bit full-adder cells
  - outputs: s[DIGIT-1:0], cout, c_msb (carry into its top bit)
- The top holds the FSM, counter, operand and result shift registers, carry register and output registers.

Test Plan:
- WIDTH=8, DIGIT=1; a=0x5A, b=0x3C, cin=0, sub=0 -> busy for 8 cycles, then done pulse; sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=1, sub=0 -> sum=0x01, cout=1, ovf=0.
- sub=1, a=0x10, b=0x20, cin=1 (ignored) -> sum=0xF0, cout=0, ovf=0.
- sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1. Then assert start with new operands while busy -> ignored; the result is unchanged.
- Drop rst_n low 3 cycles into an operation -> busy, done, sum, cout, ovf = 0 immediately, with no done afterwards. After release, a=0x01, b=0x01 -> sum=0x02.
- WIDTH=8, DIGIT=4; 0x5A+0x3C -> done 2 cycles after start, sum=0x96. Assert start in the done cycle with 0x7F+0x01 -> the next done gives sum=0x80, ovf=1, and the outputs hold 0x96 until then.
